// File: rtl/jtag_dap_seq.sv
`default_nettype none
// =====================================================================
// Module   : jtag_dap_seq
// Purpose  : Drives jtagIF through one DAP register access per upstream
//            request: optional IR load (DPACC/APACC, cached), the
//            transfer itself with WAIT retry, and the DP RDBUFF read
//            that completes a posted AP read. Also issues TAP aborts.
// Revision : 1.0 - initial release
// =====================================================================
module jtag_dap_seq #(
  parameter int unsigned WAIT_RETRIES = 16,
  parameter logic [2:0]  ACK_OK       = 3'b010,
  parameter logic [2:0]  ACK_WAIT     = 3'b001
) (
  input  logic        clk,
  input  logic        rst,
  // upstream request / result
  input  logic        go_i,
  input  logic        op_i,
  input  logic        apndp_i,
  input  logic        rnw_i,
  input  logic [1:0]  addr32_i,
  input  logic [31:0] dwrite_i,
  output logic        idle_o,
  output logic [2:0]  ack_o,
  output logic [31:0] dread_o,
  output logic        err_o,
  // jtagIF sub-command interface
  output logic [1:0]  jcmd_o,
  output logic [1:0]  jaddr32_o,
  output logic        jrnw_o,
  output logic        japndp_o,
  output logic [31:0] jdwrite_o,
  output logic        jgo_o,
  input  logic [2:0]  jack_i,
  input  logic [31:0] jdread_i,
  input  logic        jidle_i
);

  localparam logic [1:0] c_CMD_IR     = 2'd0;
  localparam logic [1:0] c_CMD_TFR    = 2'd1;
  localparam logic [1:0] c_CMD_ABORT  = 2'd2;
  // IR cache: {unknown, apndp}; unknown after reset or abort
  localparam logic [1:0] c_IR_DP      = 2'b00;
  localparam logic [1:0] c_IR_UNKNOWN = 2'b10;
  localparam logic [7:0] c_MAX_RETRY  = 8'(WAIT_RETRIES);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ABT_GO = 4'd1,
    S_ABT_WT = 4'd2,
    S_IR_GO  = 4'd3,
    S_IR_WT  = 4'd4,
    S_TFR_GO = 4'd5,
    S_TFR_WT = 4'd6,
    S_CHECK  = 4'd7,
    S_RDB_GO = 4'd8,
    S_RDB_WT = 4'd9,
    S_DONE   = 4'd10
  } state_t;

  state_t      state_q;
  state_t      wt_state_d;
  logic [1:0]  cur_ir_q;
  logic [7:0]  retry_q;
  logic [7:0]  retry_d;
  logic        rdb_q;        // set once the AP read data phase (RDBUFF) is under way
  logic        req_op_q;
  logic        req_apndp_q;
  logic        req_rnw_q;
  logic [1:0]  req_addr_q;
  logic [31:0] req_dwrite_q;
  logic        idle_q;
  logic [2:0]  ack_q;
  logic [31:0] dread_q;
  logic        err_q;
  logic [1:0]  jcmd_q;
  logic [1:0]  jaddr32_q;
  logic        jrnw_q;
  logic        japndp_q;
  logic [31:0] jdwrite_q;
  logic        jgo_q;
  logic [1:0]  cmd_d;
  logic        apndp_d;
  logic [1:0]  addr_d;
  logic        rnw_d;

  assign idle_o    = idle_q;
  assign ack_o     = ack_q;
  assign dread_o   = dread_q;
  assign err_o     = err_q;
  assign jcmd_o    = jcmd_q;
  assign jaddr32_o = jaddr32_q;
  assign jrnw_o    = jrnw_q;
  assign japndp_o  = japndp_q;
  assign jdwrite_o = jdwrite_q;
  assign jgo_o     = jgo_q;

  // Sub-command fields and follow-on wait state for whichever *_GO state is active
  always_comb begin
    cmd_d      = c_CMD_TFR;
    apndp_d    = req_apndp_q;
    addr_d     = req_addr_q;
    rnw_d      = req_rnw_q;
    wt_state_d = S_TFR_WT;
    case (state_q)
      S_ABT_GO: begin
        cmd_d      = c_CMD_ABORT;
        wt_state_d = S_ABT_WT;
      end
      S_IR_GO: begin
        // the RDBUFF phase always needs DPACC
        cmd_d      = c_CMD_IR;
        apndp_d    = req_apndp_q & ~rdb_q;
        wt_state_d = S_IR_WT;
      end
      S_RDB_GO: begin
        apndp_d    = 1'b0;
        addr_d     = 2'b11;
        rnw_d      = 1'b1;
        wt_state_d = S_RDB_WT;
      end
      default: ;
    endcase
  end

  // Saturating increment of the shared WAIT retry counter
  always_comb retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

  // Request sequencer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_ir_q     <= c_IR_UNKNOWN;
      retry_q      <= 8'd0;
      rdb_q        <= 1'b0;
      req_op_q     <= 1'b0;
      req_apndp_q  <= 1'b0;
      req_rnw_q    <= 1'b0;
      req_addr_q   <= 2'd0;
      req_dwrite_q <= 32'd0;
      idle_q       <= 1'b1;
      ack_q        <= 3'd0;
      dread_q      <= 32'd0;
      err_q        <= 1'b0;
      jcmd_q       <= 2'd0;
      jaddr32_q    <= 2'd0;
      jrnw_q       <= 1'b0;
      japndp_q     <= 1'b0;
      jdwrite_q    <= 32'd0;
      jgo_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go_i) begin
            req_op_q     <= op_i;
            req_apndp_q  <= apndp_i;
            req_rnw_q    <= rnw_i;
            req_addr_q   <= addr32_i;
            req_dwrite_q <= dwrite_i;
            idle_q       <= 1'b0;
            err_q        <= 1'b0;
            retry_q      <= 8'd0;
            rdb_q        <= 1'b0;
            if (op_i)
              state_q <= S_ABT_GO;
            else if (cur_ir_q != {1'b0, apndp_i})
              state_q <= S_IR_GO;
            else
              state_q <= S_TFR_GO;
          end
        end
        S_ABT_GO, S_IR_GO, S_TFR_GO, S_RDB_GO: begin
          // launch only into an idle jtagIF, then hold until it goes busy
          if (!jgo_q) begin
            if (jidle_i) begin
              jgo_q     <= 1'b1;
              jcmd_q    <= cmd_d;
              japndp_q  <= apndp_d;
              jaddr32_q <= addr_d;
              jrnw_q    <= rnw_d;
              jdwrite_q <= req_dwrite_q;
            end
          end else if (!jidle_i) begin
            jgo_q   <= 1'b0;
            state_q <= wt_state_d;
          end
        end
        S_ABT_WT: begin
          if (jidle_i) begin
            cur_ir_q <= c_IR_UNKNOWN;
            ack_q    <= ACK_OK;
            err_q    <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        S_IR_WT: begin
          if (jidle_i) begin
            cur_ir_q <= rdb_q ? c_IR_DP : {1'b0, req_apndp_q};
            state_q  <= rdb_q ? S_RDB_GO : S_TFR_GO;
          end
        end
        S_TFR_WT, S_RDB_WT: begin
          if (jidle_i)
            state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (jack_i == ACK_WAIT) begin
            if (retry_q < c_MAX_RETRY) begin
              retry_q <= retry_d;
              state_q <= rdb_q ? S_RDB_GO : S_TFR_GO;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end
          end else if (jack_i != ACK_OK) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else if (!rdb_q && req_apndp_q && req_rnw_q) begin
            // posted AP read: the data arrives through DP RDBUFF
            rdb_q   <= 1'b1;
            state_q <= (cur_ir_q != c_IR_DP) ? S_IR_GO : S_RDB_GO;
          end else begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // abort already set its result in S_ABT_WT
          if (!req_op_q) begin
            ack_q <= jack_i;
            if (req_rnw_q)
              dread_q <= jdread_i;
          end
          idle_q  <= 1'b1;
          retry_q <= 8'd0;
          rdb_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
